// File: rtl/pp_row_reader.sv
// Row burst reader: pulls one full row from the preprocess output FIFO when it
// holds a complete row and the line buffer can take it, tagging row/frame edges.
module pp_row_reader #(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int DATA_WIDTH = 12,
  parameter int FILL_WIDTH = 11
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_flush,
  output logic                       o_rd,
  input  logic [DATA_WIDTH-1:0]      i_data,
  input  logic [FILL_WIDTH-1:0]      i_fill,
  input  logic                       i_ready,
  output logic                       o_valid,
  output logic [DATA_WIDTH-1:0]      o_data,
  output logic                       o_sol,
  output logic                       o_eol,
  output logic                       o_sof,
  output logic                       o_eof,
  output logic [$clog2(IMG_H)-1:0]   o_row,
  output logic                       o_busy
);

  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic                    drain_q, drain_d;
  logic                    rd_q, rd_d;

  // Stage 1 carries the tags of the read issued last cycle while the FIFO
  // returns its data; stage 2 is the registered output.
  logic                    p1_valid_q, p1_valid_d;
  logic [3:0]              p1_tags_q, p1_tags_d;
  logic                    out_valid_q, out_valid_d;
  logic [3:0]              out_tags_q, out_tags_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    drain_d     = drain_q;
    rd_d        = 1'b0;
    p1_valid_d  = rd_q;
    p1_tags_d   = {col_q == '0,
                   col_q == COL_W'(IMG_W - 1),
                   (col_q == '0) && (row_q == '0),
                   (col_q == COL_W'(IMG_W - 1)) && (row_q == ROW_W'(IMG_H - 1))};
    out_valid_d = p1_valid_q;
    out_tags_d  = p1_valid_q ? p1_tags_q : 4'b0;
    out_data_d  = p1_valid_q ? i_data : out_data_q;

    case (state_q)
      IDLE: begin
        if (i_ready && (i_fill >= FILL_WIDTH'(IMG_W))) begin
          state_d = BURST;
          rd_d    = 1'b1;
          col_d   = '0;
        end
      end
      BURST: begin
        if (col_q == COL_W'(IMG_W - 1)) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end else begin
          col_d = col_q + COL_W'(1);
          rd_d  = 1'b1;
        end
      end
      DRAIN: begin
        // Second DRAIN cycle is the one in which the last pixel is presented.
        if (drain_q) begin
          state_d = IDLE;
          row_d   = (row_q == ROW_W'(IMG_H - 1)) ? '0 : row_q + ROW_W'(1);
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (i_flush) begin
      state_d     = IDLE;
      rd_d        = 1'b0;
      col_d       = '0;
      row_d       = '0;
      drain_d     = 1'b0;
      p1_valid_d  = 1'b0;
      p1_tags_d   = 4'b0;
      out_valid_d = 1'b0;
      out_tags_d  = 4'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      drain_q     <= 1'b0;
      rd_q        <= 1'b0;
      p1_valid_q  <= 1'b0;
      p1_tags_q   <= 4'b0;
      out_valid_q <= 1'b0;
      out_tags_q  <= 4'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      drain_q     <= drain_d;
      rd_q        <= rd_d;
      p1_valid_q  <= p1_valid_d;
      p1_tags_q   <= p1_tags_d;
      out_valid_q <= out_valid_d;
      out_tags_q  <= out_tags_d;
      out_data_q  <= out_data_d;
    end
  end

  assign o_rd    = rd_q;
  assign o_valid = out_valid_q;
  assign o_data  = out_data_q;
  assign o_sol   = out_tags_q[3];
  assign o_eol   = out_tags_q[2];
  assign o_sof   = out_tags_q[1];
  assign o_eof   = out_tags_q[0];
  assign o_row   = row_q;
  assign o_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_pp_row_reader.sv
// Bench for pp_row_reader: FIFO model plus scoreboard of expected pixels,
// directed phases followed by randomized ready/fill/flush traffic.
module tb_pp_row_reader;
  localparam int W  = 8;
  localparam int H  = 2;
  localparam int DW = 12;
  localparam int FW = 11;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          flush = 1'b0;
  logic          ready = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic [FW-1:0] fill = '0;
  logic          rd, valid, sol, eol, sof, eof, busy;
  logic [DW-1:0] data;
  logic [0:0]    row;

  pp_row_reader #(.IMG_W(W), .IMG_H(H), .DATA_WIDTH(DW), .FILL_WIDTH(FW)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_flush(flush), .o_rd(rd), .i_data(i_data),
    .i_fill(fill), .i_ready(ready), .o_valid(valid), .o_data(data),
    .o_sol(sol), .o_eol(eol), .o_sof(sof), .o_eof(eof), .o_row(row), .o_busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [DW-1:0] d;
    logic          sol, eol, sof, eof;
    int            idx;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] fifo_q[$];

  int vec_cnt = 0, err_cnt = 0;
  int cyc = 0, model_row = 0, rows_done = 0, run = 0, last_rd = 0, last_gap = 0;
  int last_idx = -1, last_valid_cyc = -1;
  bit have_last = 0, prev_ok = 0, rd_n = 0, seen_reset = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vec_cnt++;
    if (act !== req) begin
      err_cnt++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, req);
    end
  endtask

  // FIFO model: a read in cycle t presents the head entry throughout cycle t+1.
  initial for (int i = 0; i < 64; i++) fifo_q.push_back(DW'($urandom));
  always @(posedge clk) begin
    #1;
    if (rd_n) begin
      i_data = fifo_q.pop_front();
      fifo_q.push_back(DW'($urandom));
    end else begin
      i_data = DW'($urandom);
    end
  end

  // Monitor: reference model of rows, bursts and expected pixel stream.
  always @(negedge clk) begin
    bit   abort;
    exp_t e;
    cyc++;
    abort = !rstn || flush;
    if (seen_reset) begin
      chk("row_index", row, model_row);
      if (valid) begin
        if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("latency", cyc, e.cyc);
          chk("pixel_data", data, e.d);
          chk("pixel_tags", {sol, eol, sof, eof}, {e.sol, e.eol, e.sof, e.eof});
          last_idx = e.idx;
          last_valid_cyc = cyc;
          if (e.eol) begin
            model_row = (model_row + 1) % H;
            rows_done++;
          end
        end
      end else begin
        chk("tags_without_valid", {sol, eol, sof, eof}, 0);
      end
      if (rd) begin
        if (run == 0) begin
          chk("start_condition", prev_ok, 1);
          if (have_last) begin
            last_gap = cyc - last_rd;
            chk("burst_gap_min", last_gap >= 4, 1);
          end
          for (int i = 0; i < W; i++) begin
            e.cyc = cyc + 2 + i;
            e.d   = fifo_q[i];
            e.sol = (i == 0);
            e.eol = (i == W - 1);
            e.sof = (model_row == 0) && (i == 0);
            e.eof = (model_row == H - 1) && (i == W - 1);
            e.idx = i;
            exp_q.push_back(e);
          end
        end
        run++;
        if (run == W + 1) chk("burst_too_long", run, W);
      end else if (run > 0) begin
        chk("burst_length", run, W);
        last_rd = cyc - 1;
        have_last = 1;
        run = 0;
      end
    end
    if (abort) begin
      exp_q.delete();
      model_row = 0;
      run = 0;
      have_last = 0;
      if (!rstn) seen_reset = 1;
    end
    prev_ok = ready && (fill >= FW'(W)) && !abort;
    rd_n = rd;
  end

  task automatic wait_rows(input int target, input int budget);
    int k = 0;
    while (rows_done < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk("rows_done_in_time", rows_done >= target, 1);
    #1;
  endtask

  task automatic wait_pixel4(input int budget);
    int k = 0;
    do begin
      @(posedge clk);
      k++;
    end while (!(last_valid_cyc == cyc && last_idx == 4) && k < budget);
    chk("pixel4_seen", last_valid_cyc == cyc && last_idx == 4, 1);
    #1;
  endtask

  initial begin
    int cnt, t;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {rd, valid, data, sol, eol, sof, eof, row, busy}, 0);
    @(posedge clk); #1;
    rstn = 1; fill = 20; ready = 1;

    // Two back-to-back rows: sof on row 0, eof on row 1, row wraps, exact gap
    wait_rows(2, 100);
    ready = 0;
    chk("back_to_back_gap", last_gap, 4);
    chk("row_wrapped", row, 0);
    repeat (6) @(posedge clk); #1;

    // One pixel short of a row: never reads; then exactly a row starts a burst
    fill = 7; ready = 1; cnt = 0;
    repeat (50) begin @(negedge clk); cnt += int'(rd); end
    chk("no_read_fill_7", cnt, 0);
    @(posedge clk); #1 fill = 8;
    @(negedge clk); chk("rd_in_decision_cycle", rd, 0);
    @(posedge clk); #1 ready = 0;
    @(negedge clk); chk("rd_after_fill_8", rd, 1);
    t = rows_done;
    wait_rows(t + 1, 40);
    repeat (4) @(posedge clk); #1;

    // Not ready: no reads; ready dropped mid-burst still gives a full row
    fill = 100; ready = 0; cnt = 0;
    repeat (20) begin @(negedge clk); cnt += int'(rd); end
    chk("no_read_not_ready", cnt, 0);
    @(posedge clk); #1 ready = 1;
    repeat (3) @(posedge clk); #1 ready = 0;
    t = rows_done;
    wait_rows(t + 1, 40);

    // Flush at pixel 4 of row 1
    fill = 20; ready = 1;
    t = rows_done;
    wait_rows(t + 1, 40);
    wait_pixel4(40);
    flush = 1;
    @(posedge clk); #1 flush = 0;
    @(negedge clk);
    chk("flush_clears", {rd, valid, sol, eol, sof, eof, row}, 0);
    t = rows_done;
    wait_rows(t + 1, 40);

    // Reset in the middle of a burst, then a clean restart
    wait_pixel4(40);
    rstn = 0;
    @(posedge clk); #1 rstn = 1;
    @(negedge clk);
    chk("reset_midburst", {rd, valid, data, sol, eol, sof, eof, row, busy}, 0);
    t = rows_done;
    wait_rows(t + 1, 40);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      ready = ($urandom_range(0, 2) != 0);
      fill  = ($urandom_range(0, 3) == 0) ? FW'(7) : FW'($urandom_range(0, 30));
      flush = ($urandom_range(0, 79) == 0);
    end
    @(posedge clk); #1;
    flush = 0; ready = 0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("idle_at_end", {rd, valid, busy}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
